// File: rtl/rx_pwr_det_pkg.sv
// Shared definitions for the receive power detector: FSM state encoding and
// the derivation of the window-sum width from sample width and window length.
package rx_pwr_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_SEARCH = 2'd2,
    ST_DETECT = 2'd3
  } det_state_e;

  localparam int unsigned P_SQU_DEF      = 32'd6;
  localparam int unsigned P_WIN_LOG2_DEF = 32'd4;
  localparam int unsigned P_HIT_DEF      = 32'd3;

  // Magnitude is squ+1 bits; summing 2^win_log2 of them needs win_log2 extra bits.
  function automatic int unsigned sum_width(input int unsigned squ, input int unsigned win_log2);
    return squ + 32'd1 + win_log2;
  endfunction

  localparam int unsigned SW_DEF = sum_width(P_SQU_DEF, P_WIN_LOG2_DEF);

endpackage

// File: rtl/rx_pwr_det_if.sv
// Sample/threshold/result bundle between the magnitude stage and the detector.
interface rx_pwr_det_if
  import rx_pwr_det_pkg::*;
#(
  parameter int unsigned P_SQU      = P_SQU_DEF,
  parameter int unsigned P_WIN_LOG2 = P_WIN_LOG2_DEF
);
  localparam int unsigned SW = sum_width(P_SQU, P_WIN_LOG2);

  logic          det_en;
  logic          mag_vld;
  logic [P_SQU:0] mag_in;
  logic [SW-1:0] thr_hi;
  logic [SW-1:0] thr_lo;
  logic [SW-1:0] pwr_sum;
  logic          pwr_vld;
  logic          det_flag;
  logic          det_pulse;

  modport master (
    output det_en, mag_vld, mag_in, thr_hi, thr_lo,
    input  pwr_sum, pwr_vld, det_flag, det_pulse
  );

  modport slave (
    input  det_en, mag_vld, mag_in, thr_hi, thr_lo,
    output pwr_sum, pwr_vld, det_flag, det_pulse
  );
endinterface

// File: rtl/rx_win_sum.sv
// Sliding-window sum: N-deep delay line of accepted magnitudes, running sum
// and a saturating fill counter; exposes the next sum for same-edge decisions.
module rx_win_sum
  import rx_pwr_det_pkg::*;
#(
  parameter int unsigned P_SQU      = P_SQU_DEF,
  parameter int unsigned P_WIN_LOG2 = P_WIN_LOG2_DEF,
  localparam int unsigned SW        = sum_width(P_SQU, P_WIN_LOG2)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           acc,
  input  logic [P_SQU:0] mag_in,
  output logic [SW-1:0]  sum_nxt,
  output logic [SW-1:0]  sum_cur,
  output logic           win_vld
);
  localparam int N  = 1 << P_WIN_LOG2;
  localparam int FW = P_WIN_LOG2 + 1;
  localparam logic [FW-1:0] FILL_MAX  = FW'(N);
  localparam logic [FW-1:0] FILL_LAST = FW'(N - 1);

  logic [P_SQU:0] line_q [N];
  logic [P_SQU:0] line_d [N];
  logic [SW-1:0]  sum_q, sum_d;
  logic [FW-1:0]  fill_q, fill_d;

  // Next-state of delay line, sum and fill; the oldest slot is zero until the window fills.
  always_comb begin
    line_d = line_q;
    sum_d  = sum_q;
    fill_d = fill_q;
    if (clr) begin
      for (int i = 0; i < N; i++) line_d[i] = '0;
      sum_d  = '0;
      fill_d = '0;
    end else if (acc) begin
      line_d[0] = mag_in;
      for (int i = 1; i < N; i++) line_d[i] = line_q[i-1];
      sum_d  = sum_q + SW'(mag_in) - SW'(line_q[N-1]);
      fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
    end else begin
      line_d = line_q;
      sum_d  = sum_q;
      fill_d = fill_q;
    end
  end

  // Window state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '{default: '0};
      sum_q  <= '0;
      fill_q <= '0;
    end else begin
      line_q <= line_d;
      sum_q  <= sum_d;
      fill_q <= fill_d;
    end
  end

  assign sum_nxt = sum_d;
  assign sum_cur = sum_q;
  assign win_vld = acc & ~clr & (fill_q >= FILL_LAST);

endmodule

// File: rtl/rx_pwr_det.sv
// Carrier detector: windowed power sum with consecutive-hit entry and
// hysteretic exit; decisions use the next sum so flags align with pwr_vld.
module rx_pwr_det
  import rx_pwr_det_pkg::*;
#(
  parameter int unsigned P_SQU      = P_SQU_DEF,
  parameter int unsigned P_WIN_LOG2 = P_WIN_LOG2_DEF,
  parameter int unsigned P_HIT      = P_HIT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  rx_pwr_det_if.slave  bus
);
  localparam int unsigned SW = sum_width(P_SQU, P_WIN_LOG2);
  localparam int HW = $clog2(P_HIT + 1);
  localparam logic [HW-1:0] HIT_LAST = HW'(P_HIT - 1);

  logic          clr_s, acc_s, win_vld_s;
  logic [SW-1:0] sum_nxt_s, sum_cur_s;

  det_state_e    state_q, state_d;
  logic [HW-1:0] hit_q, hit_d;
  logic          pwr_vld_q, pwr_vld_d;
  logic          det_flag_q, det_flag_d;
  logic          det_pulse_q, det_pulse_d;

  assign clr_s = ~bus.det_en;
  assign acc_s = bus.det_en & bus.mag_vld;

  rx_win_sum #(
    .P_SQU      (P_SQU),
    .P_WIN_LOG2 (P_WIN_LOG2)
  ) u_win (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_s),
    .acc     (acc_s),
    .mag_in  (bus.mag_in),
    .sum_nxt (sum_nxt_s),
    .sum_cur (sum_cur_s),
    .win_vld (win_vld_s)
  );

  // FSM next state and hit counting; the Nth-sample window already counts as a hit candidate.
  always_comb begin
    state_d   = state_q;
    hit_d     = hit_q;
    pwr_vld_d = 1'b0;
    if (clr_s) begin
      state_d = ST_IDLE;
      hit_d   = '0;
    end else begin
      pwr_vld_d = win_vld_s;
      case (state_q)
        ST_IDLE, ST_FILL, ST_SEARCH: begin
          if (win_vld_s) begin
            if (sum_nxt_s >= bus.thr_hi) begin
              if (hit_q == HIT_LAST) begin
                state_d = ST_DETECT;
                hit_d   = '0;
              end else begin
                state_d = ST_SEARCH;
                hit_d   = hit_q + HW'(1);
              end
            end else begin
              state_d = ST_SEARCH;
              hit_d   = '0;
            end
          end else if (acc_s && (state_q == ST_IDLE)) begin
            state_d = ST_FILL;
          end else begin
            state_d = state_q;
          end
        end
        ST_DETECT: begin
          if (win_vld_s && (sum_nxt_s < bus.thr_lo)) begin
            state_d = ST_SEARCH;
            hit_d   = '0;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          hit_d   = '0;
        end
      endcase
    end
    det_flag_d  = (state_d == ST_DETECT);
    det_pulse_d = (state_d == ST_DETECT) && (state_q != ST_DETECT);
  end

  // FSM and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hit_q       <= '0;
      pwr_vld_q   <= 1'b0;
      det_flag_q  <= 1'b0;
      det_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hit_q       <= hit_d;
      pwr_vld_q   <= pwr_vld_d;
      det_flag_q  <= det_flag_d;
      det_pulse_q <= det_pulse_d;
    end
  end

  assign bus.pwr_sum   = sum_cur_s;
  assign bus.pwr_vld   = pwr_vld_q;
  assign bus.det_flag  = det_flag_q;
  assign bus.det_pulse = det_pulse_q;

endmodule

// File: tb/tb_rx_pwr_det.sv
// Directed bench for rx_pwr_det with a behavioural scoreboard model.
module tb_rx_pwr_det;
  import rx_pwr_det_pkg::*;

  localparam int SW    = 11;
  localparam int N     = 16;
  localparam int P_HIT = 3;

  typedef struct {
    int sum;
    bit vld;
    bit flag;
    bit pulse;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rx_pwr_det_if #(.P_SQU(6), .P_WIN_LOG2(4)) bus ();

  rx_pwr_det #(.P_SQU(6), .P_WIN_LOG2(4), .P_HIT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   hist[$];
  int   m_fill, m_hit, m_sum;
  bit   m_det;
  int   thr_hi_i = 150;
  int   thr_lo_i = 100;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    m_fill = 0; m_hit = 0; m_sum = 0; m_det = 1'b0;
  endtask

  // Reference behaviour for one cycle; pushes the expected outputs.
  task automatic model_cycle(input bit en, input bit vld, input int mag);
    exp_t e;
    e.vld = 1'b0; e.pulse = 1'b0;
    if (!en) begin
      model_clear();
    end else if (vld) begin
      hist.push_front(mag);
      if (hist.size() > N) void'(hist.pop_back());
      if (m_fill < N) m_fill++;
      m_sum = 0;
      foreach (hist[i]) m_sum += hist[i];
      if (m_fill == N) begin
        e.vld = 1'b1;
        if (m_det) begin
          if (m_sum < thr_lo_i) begin m_det = 1'b0; m_hit = 0; end
        end else if (m_sum >= thr_hi_i) begin
          m_hit++;
          if (m_hit == P_HIT) begin m_det = 1'b1; m_hit = 0; e.pulse = 1'b1; end
        end else begin
          m_hit = 0;
        end
      end
    end
    e.sum  = m_sum;
    e.flag = m_det;
    sb.push_back(e);
  endtask

  task automatic step(input bit en, input bit vld, input int mag);
    exp_t e;
    bus.det_en  = en;
    bus.mag_vld = vld;
    bus.mag_in  = 7'(mag);
    model_cycle(en, vld, mag);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("pwr_sum",   32'(bus.pwr_sum),   32'(e.sum));
    chk("pwr_vld",   32'(bus.pwr_vld),   32'(e.vld));
    chk("det_flag",  32'(bus.det_flag),  32'(e.flag));
    chk("det_pulse", 32'(bus.det_pulse), 32'(e.pulse));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sum"},   32'(bus.pwr_sum),   32'd0);
    chk({tag, "_vld"},   32'(bus.pwr_vld),   32'd0);
    chk({tag, "_flag"},  32'(bus.det_flag),  32'd0);
    chk({tag, "_pulse"}, 32'(bus.det_pulse), 32'd0);
  endtask

  int seq22[21] = '{0, 20, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 0, 0, 30, 10, 10};

  initial begin
    rst = 1'b1;
    bus.det_en  = 1'b0;
    bus.mag_vld = 1'b0;
    bus.mag_in  = 7'd0;
    bus.thr_hi  = 11'd150;
    bus.thr_lo  = 11'd100;
    model_clear();
    #22;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Idle cycles with enable but no valid
    step(1'b1, 1'b0, 33);
    step(1'b1, 1'b0, 0);

    // Constant 10: first window on sample 16, detect on sample 18
    for (int i = 1; i <= 18; i++) begin
      step(1'b1, 1'b1, 10);
      if (i == 15) chk("fill_no_vld15", 32'(bus.pwr_vld), 32'd0);
      if (i == 16) begin
        chk("first_vld16", 32'(bus.pwr_vld), 32'd1);
        chk("sum16", 32'(bus.pwr_sum), 32'd160);
      end
      if (i == 17) chk("no_det17", 32'(bus.det_flag), 32'd0);
      if (i == 18) begin
        chk("det18", 32'(bus.det_flag), 32'd1);
        chk("pulse18", 32'(bus.det_pulse), 32'd1);
      end
    end
    step(1'b1, 1'b1, 10);
    chk("pulse_once", 32'(bus.det_pulse), 32'd0);

    // Zeros: sum falls by 10, exit on 7th (90); 100 == thr_lo holds
    for (int k = 1; k <= 7; k++) begin
      step(1'b1, 1'b1, 0);
      chk("sum_fall", 32'(bus.pwr_sum), 32'(160 - 10 * k));
      chk("det_hold", 32'(bus.det_flag), (k < 7) ? 32'd1 : 32'd0);
    end

    // Re-detect, then drop enable for one cycle while detecting
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 10);
    chk("redetect", 32'(bus.det_flag), 32'd1);
    step(1'b0, 1'b1, 10);
    chk_all_zero("en_low");
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b1, 10);
      if (i < 16) chk("refill_no_vld", 32'(bus.pwr_vld), 32'd0);
      else        chk("refill_vld16", 32'(bus.pwr_vld), 32'd1);
    end

    // Hit pattern 160,160,140,160,160,160: detect only on the 6th window
    step(1'b0, 1'b0, 0);
    for (int i = 0; i < 21; i++) begin
      step(1'b1, 1'b1, seq22[i]);
      if (i == 17) chk("dip140", 32'(bus.pwr_sum), 32'd140);
      if (i >= 15 && i < 20) chk("no_det_early", 32'(bus.det_flag), 32'd0);
    end
    chk("det_3rd_consec", 32'(bus.det_flag), 32'd1);
    chk("pulse_3rd_consec", 32'(bus.det_pulse), 32'd1);

    // Full-scale window, then valid gaps with junk magnitude
    step(1'b0, 1'b0, 0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 127);
    chk("max_sum", 32'(bus.pwr_sum), 32'd2032);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 127);
      step(1'b1, 1'b0, 55);
      chk("gap_sum", 32'(bus.pwr_sum), 32'd2032);
      chk("gap_vld", 32'(bus.pwr_vld), 32'd0);
    end

    // Asynchronous reset at sample 10 discards history
    step(1'b0, 1'b0, 0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 10);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    model_clear();
    #2 rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b1, 10);
      if (i == 15) chk("post_rst_no_vld", 32'(bus.pwr_vld), 32'd0);
      if (i == 16) chk("post_rst_vld16", 32'(bus.pwr_vld), 32'd1);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
